id_stage_hz: RTL and testbench

Parametrised successor to the pipeline's instruction-decode stage: decodes a 32-bit MIPS instruction, reads a configurable register file, sign-extends the immediate and registers everything into the ID/EX pipeline register. It adds what the first generation lacked: a valid bit, write-back bypass, load-use hazard detection with bubble insertion, branch flush and a saturating stall counter. It sits between the IF/ID register and the EX stage.

---
 rtl/id_stage_hz.sv | 156 +++++++++++++++
 tb/tb_id_stage_hz.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_hz.sv
// MIPS instruction-decode stage: control decode, register file with optional
// write-back bypass, load-use stall with bubble insertion, branch flush and a
// saturating stall counter, all feeding the ID/EX pipeline register.
module id_stage_hz #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int WB_BYPASS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           if_id_instr,
    input  logic [DATA_W-1:0]     if_id_npc,
    input  logic                  if_id_valid,
    input  logic                  wb_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_writereg,
    input  logic [DATA_W-1:0]     wb_writedata,
    input  logic                  ex_flush,
    output logic                  stall,
    output logic                  id_ex_valid,
    output logic [1:0]            id_ex_wb,
    output logic [2:0]            id_ex_m,
    output logic [3:0]            id_ex_ex,
    output logic [DATA_W-1:0]     id_ex_npc,
    output logic [DATA_W-1:0]     id_ex_reg1,
    output logic [DATA_W-1:0]     id_ex_reg2,
    output logic [DATA_W-1:0]     id_ex_sign_ext,
    output logic [REG_ADDR_W-1:0] id_ex_instr25_21,
    output logic [REG_ADDR_W-1:0] id_ex_instr20_16,
    output logic [REG_ADDR_W-1:0] id_ex_instr15_11,
    output logic [15:0]           stall_cnt
);

    localparam int DEPTH = 1 << REG_ADDR_W;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef struct packed {
        logic [1:0] wb;
        logic [2:0] m;
        logic [3:0] ex;
    } ctrl_t;

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    ctrl_t                 ctrl;
    logic                  uses_rt;
    logic [DATA_W-1:0]     rs_val;
    logic [DATA_W-1:0]     rt_val;
    logic [DATA_W-1:0]     sign_ext;
    logic                  rs_hit;
    logic                  rt_hit;
    logic [15:0]           stall_cnt_q;
    logic [DATA_W-1:0]     regs [DEPTH];

    assign opcode   = if_id_instr[31:26];
    assign rs       = if_id_instr[21 +: REG_ADDR_W];
    assign rt       = if_id_instr[16 +: REG_ADDR_W];
    assign rd       = if_id_instr[11 +: REG_ADDR_W];
    assign sign_ext = {{(DATA_W-16){if_id_instr[15]}}, if_id_instr[15:0]};

    always_comb begin
        // NOTE: defaults first so every path assigns ctrl/uses_rt and no latch is inferred.
        ctrl    = '0;
        uses_rt = 1'b0;
        case (opcode_e'(opcode))
            OP_RTYPE: begin ctrl = {2'b10, 3'b000, 4'b1100}; uses_rt = 1'b1; end
            OP_LW:    begin ctrl = {2'b11, 3'b010, 4'b0001}; end
            OP_SW:    begin ctrl = {2'b00, 3'b001, 4'b0001}; uses_rt = 1'b1; end
            OP_BEQ:   begin ctrl = {2'b00, 3'b100, 4'b0010}; uses_rt = 1'b1; end
            OP_ADDI:  begin ctrl = {2'b10, 3'b000, 4'b0001}; end
            default:  ;
        endcase
    end

    // Entry 0 is hard-wired to zero; bypass never applies to it either.
    function automatic logic [DATA_W-1:0] read_port(input logic [REG_ADDR_W-1:0] addr);
        if (addr == '0)
            return '0;
        if ((WB_BYPASS != 0) && wb_regwrite && (wb_writereg == addr))
            return wb_writedata;
        return regs[addr];
    endfunction

    assign rs_val = read_port(rs);
    assign rt_val = read_port(rt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the register file is cleared by reset, which rules out mapping it to a RAM macro.
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (wb_regwrite && (wb_writereg != '0)) begin
            regs[wb_writereg] <= wb_writedata;
        end
    end

    // Load-use: the load in EX writes rt, which ID wants to read this cycle.
    assign rs_hit = (id_ex_instr20_16 == rs);
    assign rt_hit = uses_rt && (id_ex_instr20_16 == rt);
    assign stall  = if_id_valid && id_ex_valid && id_ex_m[1] &&
                    (id_ex_instr20_16 != '0) && !ex_flush && (rs_hit || rt_hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex_valid      <= 1'b0;
            id_ex_wb         <= '0;
            id_ex_m          <= '0;
            id_ex_ex         <= '0;
            id_ex_npc        <= '0;
            id_ex_reg1       <= '0;
            id_ex_reg2       <= '0;
            id_ex_sign_ext   <= '0;
            id_ex_instr25_21 <= '0;
            id_ex_instr20_16 <= '0;
            id_ex_instr15_11 <= '0;
        end else begin
            // NOTE: non-blocking so every pipeline register samples pre-edge values.
            id_ex_npc        <= if_id_npc;
            id_ex_reg1       <= rs_val;
            id_ex_reg2       <= rt_val;
            id_ex_sign_ext   <= sign_ext;
            id_ex_instr25_21 <= rs;
            id_ex_instr20_16 <= rt;
            id_ex_instr15_11 <= rd;
            if (ex_flush || stall || !if_id_valid) begin
                id_ex_valid <= 1'b0;
                id_ex_wb    <= '0;
                id_ex_m     <= '0;
                id_ex_ex    <= '0;
            end else begin
                id_ex_valid <= 1'b1;
                id_ex_wb    <= ctrl.wb;
                id_ex_m     <= ctrl.m;
                id_ex_ex    <= ctrl.ex;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt_q <= '0;
        else if (stall && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_hz.sv
// Scoreboard bench for id_stage_hz: directed vectors push expected ID/EX contents,
// a monitor pops and compares one entry after each rising edge.
module tb_id_stage_hz;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] if_id_instr = '0;
    logic [31:0] if_id_npc = '0;
    logic        if_id_valid = 1'b0;
    logic        wb_regwrite = 1'b0;
    logic [4:0]  wb_writereg = '0;
    logic [31:0] wb_writedata = '0;
    logic        ex_flush = 1'b0;

    logic        stall, id_ex_valid;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_m;
    logic [3:0]  id_ex_ex;
    logic [31:0] id_ex_npc, id_ex_reg1, id_ex_reg2, id_ex_sign_ext;
    logic [4:0]  id_ex_instr25_21, id_ex_instr20_16, id_ex_instr15_11;
    logic [15:0] stall_cnt;

    logic        nb_stall, nb_valid;
    logic [1:0]  nb_wb;
    logic [2:0]  nb_m;
    logic [3:0]  nb_ex;
    logic [31:0] nb_npc, nb_reg1, nb_reg2, nb_sign_ext;
    logic [4:0]  nb_rs, nb_rt, nb_rd;
    logic [15:0] nb_stall_cnt;

    always #5 clk = ~clk;

    id_stage_hz #(.DATA_W(32), .REG_ADDR_W(5), .WB_BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .if_id_instr(if_id_instr), .if_id_npc(if_id_npc),
        .if_id_valid(if_id_valid), .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg),
        .wb_writedata(wb_writedata), .ex_flush(ex_flush), .stall(stall),
        .id_ex_valid(id_ex_valid), .id_ex_wb(id_ex_wb), .id_ex_m(id_ex_m), .id_ex_ex(id_ex_ex),
        .id_ex_npc(id_ex_npc), .id_ex_reg1(id_ex_reg1), .id_ex_reg2(id_ex_reg2),
        .id_ex_sign_ext(id_ex_sign_ext), .id_ex_instr25_21(id_ex_instr25_21),
        .id_ex_instr20_16(id_ex_instr20_16), .id_ex_instr15_11(id_ex_instr15_11),
        .stall_cnt(stall_cnt)
    );

    id_stage_hz #(.DATA_W(32), .REG_ADDR_W(5), .WB_BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst), .if_id_instr(if_id_instr), .if_id_npc(if_id_npc),
        .if_id_valid(if_id_valid), .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg),
        .wb_writedata(wb_writedata), .ex_flush(ex_flush), .stall(nb_stall),
        .id_ex_valid(nb_valid), .id_ex_wb(nb_wb), .id_ex_m(nb_m), .id_ex_ex(nb_ex),
        .id_ex_npc(nb_npc), .id_ex_reg1(nb_reg1), .id_ex_reg2(nb_reg2),
        .id_ex_sign_ext(nb_sign_ext), .id_ex_instr25_21(nb_rs),
        .id_ex_instr20_16(nb_rt), .id_ex_instr15_11(nb_rd),
        .stall_cnt(nb_stall_cnt)
    );

    typedef struct {
        logic        valid;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] npc;
        logic [31:0] reg1;
        logic [31:0] reg1_nb;
        logic [31:0] reg2;
        logic [31:0] sext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] cnt;
        int          vec;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          vec = 0;
    logic [31:0] npc_ctr = 32'h100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one IF/ID cycle at the falling edge and check the combinational stall.
    task automatic cyc(input logic [31:0] instr, input logic v, input logic fl,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic exp_stall);
        @(negedge clk);
        vec++;
        if_id_instr  = instr;
        if_id_valid  = v;
        ex_flush     = fl;
        wb_regwrite  = we;
        wb_writereg  = wr;
        wb_writedata = wd;
        if_id_npc    = npc_ctr;
        npc_ctr      = npc_ctr + 32'd4;
        #1;
        check($sformatf("stall[v%0d]", vec), 64'(stall), 64'(exp_stall));
    endtask

    task automatic push(input logic v, input logic [1:0] wb, input logic [2:0] m,
                        input logic [3:0] ex, input logic [31:0] r1, input logic [31:0] r1_nb,
                        input logic [31:0] r2, input logic [31:0] sx, input logic [15:0] cnt);
        exp_t e;
        e.valid = v;   e.wb = wb;      e.m = m;     e.ex = ex;
        e.reg1  = r1;  e.reg1_nb = r1_nb; e.reg2 = r2; e.sext = sx;
        e.cnt   = cnt; e.npc = if_id_npc; e.vec = vec;
        e.rs    = if_id_instr[25:21];
        e.rt    = if_id_instr[20:16];
        e.rd    = if_id_instr[15:11];
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("valid[v%0d]", e.vec), 64'(id_ex_valid), 64'(e.valid));
                check($sformatf("wb[v%0d]", e.vec), 64'(id_ex_wb), 64'(e.wb));
                check($sformatf("m[v%0d]", e.vec), 64'(id_ex_m), 64'(e.m));
                check($sformatf("ex[v%0d]", e.vec), 64'(id_ex_ex), 64'(e.ex));
                check($sformatf("stall_cnt[v%0d]", e.vec), 64'(stall_cnt), 64'(e.cnt));
                if (e.valid) begin
                    check($sformatf("npc[v%0d]", e.vec), 64'(id_ex_npc), 64'(e.npc));
                    check($sformatf("reg1[v%0d]", e.vec), 64'(id_ex_reg1), 64'(e.reg1));
                    check($sformatf("reg1_nobypass[v%0d]", e.vec), 64'(nb_reg1), 64'(e.reg1_nb));
                    check($sformatf("reg2[v%0d]", e.vec), 64'(id_ex_reg2), 64'(e.reg2));
                    check($sformatf("sign_ext[v%0d]", e.vec), 64'(id_ex_sign_ext), 64'(e.sext));
                    check($sformatf("rs[v%0d]", e.vec), 64'(id_ex_instr25_21), 64'(e.rs));
                    check($sformatf("rt[v%0d]", e.vec), 64'(id_ex_instr20_16), 64'(e.rt));
                    check($sformatf("rd[v%0d]", e.vec), 64'(id_ex_instr15_11), 64'(e.rd));
                end
            end
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, 64'(id_ex_valid), 64'(0));
        check({tag, "_ctrl"}, 64'({id_ex_wb, id_ex_m, id_ex_ex}), 64'(0));
        check({tag, "_npc"}, 64'(id_ex_npc), 64'(0));
        check({tag, "_data"}, 64'(id_ex_reg1 | id_ex_reg2 | id_ex_sign_ext), 64'(0));
        check({tag, "_fields"}, 64'({id_ex_instr25_21, id_ex_instr20_16, id_ex_instr15_11}), 64'(0));
        check({tag, "_stall"}, 64'(stall), 64'(0));
        check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(0));
    endtask

    initial begin : stimulus
        // Reset with arbitrary activity on the inputs, including a write-back to reg 5.
        if_id_instr = 32'h8C120000; if_id_valid = 1'b1; if_id_npc = 32'hFFFF_0000;
        wb_regwrite = 1'b1; wb_writereg = 5'd5; wb_writedata = 32'h1234;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        if_id_valid = 1'b0; wb_regwrite = 1'b0;
        rst = 1'b1;

        // v1 lw $18
        cyc(32'h8C120000, 1, 0, 0, 5'd0, 32'h0, 0);
        push(1, 2'b11, 3'b010, 4'b0001, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0);
        // v2 no instruction; write reg 9 = 5
        cyc(32'h00000000, 0, 0, 1, 5'd9, 32'h5, 0);
        push(0, 2'b00, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0);
        // v3/v4 addi rs=9, positive and negative immediates
        cyc(32'h21310010, 1, 0, 0, 5'd0, 32'h0, 0);
        push(1, 2'b10, 3'b000, 4'b0001, 32'h5, 32'h5, 32'h0, 32'h10, 16'd0);
        cyc(32'h2131FFF0, 1, 0, 0, 5'd0, 32'h0, 0);
        push(1, 2'b10, 3'b000, 4'b0001, 32'h5, 32'h5, 32'h0, 32'hFFFFFFF0, 16'd0);
        // v5 same-cycle write of reg 9: bypass sees new value, non-bypass the old one
        cyc(32'h21310010, 1, 0, 1, 5'd9, 32'hAAAA5555, 0);
        push(1, 2'b10, 3'b000, 4'b0001, 32'hAAAA5555, 32'h5, 32'h0, 32'h10, 16'd0);
        // v6 write to reg 0 while reading rs=0
        cyc(32'h20110010, 1, 0, 1, 5'd0, 32'hDEADBEEF, 0);
        push(1, 2'b10, 3'b000, 4'b0001, 32'h0, 32'h0, 32'h0, 32'h10, 16'd0);
        // v7 reg 9 now stored in both instances
        cyc(32'h21310010, 1, 0, 0, 5'd0, 32'h0, 0);
        push(1, 2'b10, 3'b000, 4'b0001, 32'hAAAA5555, 32'hAAAA5555, 32'h0, 32'h10, 16'd0);
        // v8 reg 5 (written only under reset) and reg 0 read as 0; write reg 18 = 0x77
        cyc(32'h20A00000, 1, 0, 1, 5'd18, 32'h77, 0);
        push(1, 2'b10, 3'b000, 4'b0001, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0);
        // v9-v11 lw $18 then add rs=18: one stall, bubble, then the add issues
        cyc(32'h8C120000, 1, 0, 0, 5'd0, 32'h0, 0);
        push(1, 2'b11, 3'b010, 4'b0001, 32'h0, 32'h0, 32'h77, 32'h0, 16'd0);
        cyc(32'h02400020, 1, 0, 0, 5'd0, 32'h0, 1);
        push(0, 2'b00, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 16'd1);
        cyc(32'h02400020, 1, 0, 0, 5'd0, 32'h0, 0);
        push(1, 2'b10, 3'b000, 4'b1100, 32'h77, 32'h77, 32'h0, 32'h20, 16'd1);
        // v12-v13 same hazard with flush: no stall, bubble, counter unchanged
        cyc(32'h8C120000, 1, 0, 0, 5'd0, 32'h0, 0);
        push(1, 2'b11, 3'b010, 4'b0001, 32'h0, 32'h0, 32'h77, 32'h0, 16'd1);
        cyc(32'h02400020, 1, 1, 0, 5'd0, 32'h0, 0);
        push(0, 2'b00, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 16'd1);
        // v14 unknown opcode 0x3F: valid with all controls zero
        cyc(32'hFC000000, 1, 0, 0, 5'd0, 32'h0, 0);
        push(1, 2'b00, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 16'd1);
        // v15-v17 lw $18 then sw with rt=18: rt hazard applies to stores
        cyc(32'h8C120000, 1, 0, 0, 5'd0, 32'h0, 0);
        push(1, 2'b11, 3'b010, 4'b0001, 32'h0, 32'h0, 32'h77, 32'h0, 16'd1);
        cyc(32'hAC120004, 1, 0, 0, 5'd0, 32'h0, 1);
        push(0, 2'b00, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 16'd2);
        cyc(32'hAC120004, 1, 0, 0, 5'd0, 32'h0, 0);
        push(1, 2'b00, 3'b001, 4'b0001, 32'h0, 32'h0, 32'h77, 32'h4, 16'd2);
        // v18-v19 lw $18 then addi with rt=18: rt is a destination, no stall
        cyc(32'h8C120000, 1, 0, 0, 5'd0, 32'h0, 0);
        push(1, 2'b11, 3'b010, 4'b0001, 32'h0, 32'h0, 32'h77, 32'h0, 16'd2);
        cyc(32'h20120001, 1, 0, 0, 5'd0, 32'h0, 0);
        push(1, 2'b10, 3'b000, 4'b0001, 32'h0, 32'h0, 32'h77, 32'h1, 16'd2);
        // v20 beq
        cyc(32'h10000003, 1, 0, 0, 5'd0, 32'h0, 0);
        push(1, 2'b00, 3'b100, 4'b0010, 32'h0, 32'h0, 32'h0, 32'h3, 16'd2);

        // lw $18,0($18) held in IF/ID: stalls on every other cycle
        cyc(32'h8E520000, 1, 0, 0, 5'd0, 32'h0, 0);
        repeat (200) @(negedge clk);
        #1;
        check("stall_cnt_after_100_stalls", 64'(stall_cnt), 64'(16'd102));

        // Preload the counter just below saturation, then keep stalling.
        force u_dut.stall_cnt_q = 16'hFFFD;
        #1;
        release u_dut.stall_cnt_q;
        repeat (11) @(negedge clk);
        #1;
        check("stall_cnt_saturated", 64'(stall_cnt), 64'(16'hFFFF));
        check("stall_before_reset", 64'(stall), 64'(1));

        // Reset mid-stall, well before the next rising edge.
        #2;
        rst = 1'b0;
        #1;
        check_cleared("async_reset");

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
